imem_loader: RTL

- Write-side counterpart to the byte-addressed, little-endian instruction memory.
- Accepts 32-bit instruction words over a valid/ready handshake and writes each one as four byte writes to consecutive addresses, low byte first.
- Used to program instruction memory before the single-cycle core runs; `busy` holds the core in stall until loading completes.

---
 rtl/imem_loader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes 32-bit words over valid/ready and writes
// each one as four little-endian byte writes to consecutive addresses.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  word_valid,
  input  logic [31:0]           word_data,
  input  logic                  word_last,
  output logic                  word_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH-1:0] word_count,
  output logic [2:0]            state_dbg
);

  // Handshake: a word transfers on a rising edge where word_valid and
  // word_ready are both high; word_data/word_last are sampled on that edge only.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_WRITE  = 3'd2,
    S_DONE   = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH:0]   BASE_PTR  = (ADDR_WIDTH+1)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   PTR_STEP  = (ADDR_WIDTH+1)'(4);
  localparam logic [ADDR_WIDTH-1:0] COUNT_MAX = '1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   ptr_q, ptr_d;
  logic [1:0]            idx_q, idx_d;
  logic [31:0]           data_q, data_d;
  logic                  last_q, last_d;
  logic                  word_ready_q, word_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_wdata_q, mem_wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  overflow_q, overflow_d;
  logic [ADDR_WIDTH-1:0] word_count_q, word_count_d;

  logic [ADDR_WIDTH:0]   ptr_next;
  logic [1:0]            idx_inc;

  // One extra pointer bit lets a full memory show up as bit ADDR_WIDTH set.
  assign ptr_next = ptr_q + PTR_STEP;
  assign idx_inc  = idx_q + 2'd1;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    data_d       = data_q;
    last_d       = last_q;
    word_ready_d = word_ready_q;
    busy_d       = busy_q;
    done_d       = done_q;
    overflow_d   = overflow_q;
    word_count_d = word_count_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d      = S_ACCEPT;
          ptr_d        = BASE_PTR;
          word_count_d = '0;
          done_d       = 1'b0;
          overflow_d   = 1'b0;
          word_ready_d = 1'b1;
          busy_d       = 1'b1;
        end
      end
      S_ACCEPT: begin
        if (word_valid && word_ready_q) begin
          state_d      = S_WRITE;
          data_d       = word_data;
          last_d       = word_last;
          idx_d        = 2'd0;
          word_ready_d = 1'b0;
          mem_we_d     = 1'b1;
          mem_addr_d   = ptr_q[ADDR_WIDTH-1:0];
          mem_wdata_d  = word_data[7:0];
        end
      end
      S_WRITE: begin
        if (idx_q != 2'd3) begin
          idx_d       = idx_inc;
          mem_we_d    = 1'b1;
          mem_addr_d  = ptr_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(idx_inc);
          mem_wdata_d = data_q[{idx_inc, 3'b000} +: 8];
        end else begin
          ptr_d = ptr_next;
          if (word_count_q != COUNT_MAX) begin
            word_count_d = word_count_q + 1'b1;
          end
          if (last_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else if (ptr_next[ADDR_WIDTH]) begin
            state_d    = S_ERROR;
            overflow_d = 1'b1;
            busy_d     = 1'b0;
          end else begin
            state_d      = S_ACCEPT;
            word_ready_d = 1'b1;
          end
        end
      end
      default: begin
        state_d      = S_IDLE;
        word_ready_d = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= BASE_PTR;
      idx_q        <= 2'd0;
      data_q       <= '0;
      last_q       <= 1'b0;
      word_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      last_q       <= last_d;
      word_ready_q <= word_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
      word_count_q <= word_count_d;
    end
  end

  assign word_ready = word_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign word_count = word_count_q;
  assign state_dbg  = state_q;

endmodule
